// File: rtl/gcd_pkg.sv
// Shared definitions for the two-requester GCD arbiter.
// Holds the FSM encoding, default width and the count-width helper.
package gcd_pkg;

    // Default operand/result width in bits.
    localparam int GCD_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the shared power-of-two counter.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// Request/result bundle between two requesters, one consumer and the arbiter.
// master: requesters + consumer side; slave: the arbiter itself.
interface gcd_arbiter_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) ();

    logic             req0_valid;
    logic [WIDTH-1:0] req0_x;
    logic [WIDTH-1:0] req0_y;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_x;
    logic [WIDTH-1:0] req1_y;
    logic             req1_ready;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_g;
    logic             res_id;

    logic             busy;

    modport master (
        output req0_valid, req0_x, req0_y,
        output req1_valid, req1_x, req1_y,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_g, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_x, req0_y,
        input  req1_valid, req1_x, req1_y,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_g, res_id, busy
    );

endinterface

// File: rtl/gcd_step.sv
// One combinational binary-GCD step on the working pair (a, b, count).
// Ports: a_i/b_i/cnt_i current values; a_o/b_o/cnt_o next values; eq_o a==b.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [CW-1:0]    cnt_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [CW-1:0]    cnt_o,
    output logic             eq_o
);

    logic a_ev;
    logic b_ev;

    assign eq_o = (a_i == b_i);
    assign a_ev = ~a_i[0];
    assign b_ev = ~b_i[0];

    always_comb begin
        a_o   = a_i;
        b_o   = b_i;
        cnt_o = cnt_i;
        unique case (1'b1)
            eq_o: begin
                a_o = a_i;
            end
            (!eq_o && a_ev && b_ev): begin
                // Common factor of two: remember it in count.
                a_o   = a_i >> 1;
                b_o   = b_i >> 1;
                cnt_o = cnt_i + CW'(1);
            end
            (!eq_o && a_ev && !b_ev): begin
                a_o = a_i >> 1;
            end
            (!eq_o && !a_ev && b_ev): begin
                b_o = b_i >> 1;
            end
            default: begin
                // Both odd: difference is even and never underflows.
                if (a_i >= b_i) begin
                    a_o = a_i - b_i;
                end else begin
                    b_o = b_i - a_i;
                end
            end
        endcase
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one iterative binary-GCD engine by two requesters.
// Ports: clk, rst_n (async, active-low), bus_if (gcd_arbiter_if.slave).
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    gcd_arbiter_if.slave bus_if
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             id_q, id_d;
    logic             last_q, last_d;

    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;
    logic [CW-1:0]    step_cnt;
    logic             step_eq;

    logic             v0;
    logic             v1;
    logic             gnt1;
    logic             idle;
    logic             accept;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;

    gcd_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_step (
        .a_i   (a_q),
        .b_i   (b_q),
        .cnt_i (cnt_q),
        .a_o   (step_a),
        .b_o   (step_b),
        .cnt_o (step_cnt),
        .eq_o  (step_eq)
    );

    assign v0   = bus_if.req0_valid;
    assign v1   = bus_if.req1_valid;
    assign idle = (state_q == ST_IDLE);

    // last_q is the requester served most recently; the other one
    // wins a tie. Reset sets it to 1 so requester 0 wins first.
    always_comb begin
        gnt1 = 1'b0;
        unique case (1'b1)
            (v0 && v1):  gnt1 = ~last_q;
            (!v0 && v1): gnt1 = 1'b1;
            default:     gnt1 = 1'b0;
        endcase
    end

    assign accept = idle && (v0 || v1);
    assign sel_x  = gnt1 ? bus_if.req1_x : bus_if.req0_x;
    assign sel_y  = gnt1 ? bus_if.req1_y : bus_if.req0_y;

    assign bus_if.req0_ready = idle && v0 && !gnt1;
    assign bus_if.req1_ready = idle && v1 && gnt1;
    assign bus_if.res_valid  = (state_q == ST_DONE);
    assign bus_if.res_g      = g_q;
    assign bus_if.res_id     = id_q;
    assign bus_if.busy       = !idle;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        id_d    = id_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d    = sel_x;
                    b_d    = sel_y;
                    cnt_d  = '0;
                    id_d   = gnt1;
                    last_d = gnt1;
                    // A zero operand makes the other one the answer.
                    if (sel_x == '0 || sel_y == '0) begin
                        g_d     = sel_x | sel_y;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (step_eq) begin
                    // Restore the common powers of two stripped earlier.
                    g_d     = a_q << cnt_q;
                    state_d = ST_DONE;
                end else begin
                    a_d   = step_a;
                    b_d   = step_b;
                    cnt_d = step_cnt;
                end
            end
            ST_DONE: begin
                if (bus_if.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            g_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: vector table plus corner sequences.
// Results are scored against a Euclid reference through an expectation queue.
module tb_gcd_arbiter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gcd_arbiter_if #(.WIDTH(W)) bus ();

    gcd_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] g;
    } exp_t;

    typedef struct {
        logic         id;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] g;
    } vec_t;

    exp_t         sbq[$];
    vec_t         vt[10];
    int           total = 0;
    int           bad = 0;
    int           nres = 0;
    logic [W-1:0] last_g = '0;
    logic         last_id = 1'b0;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        int a;
        int b;
        int t;
        a = int'(x);
        b = int'(y);
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return W'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.req0_valid && bus.req0_ready)
                sbq.push_back('{1'b0, ref_gcd(bus.req0_x, bus.req0_y)});
            if (bus.req1_valid && bus.req1_ready)
                sbq.push_back('{1'b1, ref_gcd(bus.req1_x, bus.req1_y)});
            if (bus.res_valid && bus.res_ready) begin
                nres++;
                last_g  = bus.res_g;
                last_id = bus.res_id;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got g=%0d id=%0d want none",
                             bus.res_g, bus.res_id);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_g", 32'(bus.res_g), 32'(e.g));
                    chk("sb_id", 32'(bus.res_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_x     = '0;
        bus.req0_y     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_x     = '0;
        bus.req1_y     = '0;
    endtask

    task automatic drive(input logic id, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_x     = x;
            bus.req1_y     = y;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_x     = x;
            bus.req0_y     = y;
        end
    endtask

    // Present a request, wait for its accept edge, then withdraw it.
    task automatic send(input logic id, input logic [W-1:0] x,
                        input logic [W-1:0] y);
        int n;
        logic rdy;
        drive(id, x, y);
        #1;
        n = 0;
        rdy = id ? bus.req1_ready : bus.req0_ready;
        while (!rdy && n < 50) begin
            tick();
            n++;
            rdy = id ? bus.req1_ready : bus.req0_ready;
        end
        if (!rdy) begin
            chk("accept_timeout", 32'(rdy), 32'd1);
        end
        tick();
        clear_inputs();
    endtask

    task automatic wait_res(input int target, input int budget);
        int n;
        n = 0;
        while (nres < target && n < budget) begin
            tick();
            n++;
        end
        chk("res_arrived", 32'(nres), 32'(target));
    endtask

    initial begin
        int k;
        int base;

        vt[0] = '{1'b0, 4'd7,  4'd3,  4'd1};
        vt[1] = '{1'b1, 4'd8,  4'd12, 4'd4};
        vt[2] = '{1'b0, 4'd15, 4'd15, 4'd15};
        vt[3] = '{1'b1, 4'd1,  4'd14, 4'd1};
        vt[4] = '{1'b0, 4'd14, 4'd7,  4'd7};
        vt[5] = '{1'b1, 4'd9,  4'd0,  4'd9};
        vt[6] = '{1'b0, 4'd6,  4'd9,  4'd3};
        vt[7] = '{1'b1, 4'd15, 4'd5,  4'd5};
        vt[8] = '{1'b0, 4'd10, 4'd4,  4'd2};
        vt[9] = '{1'b1, 4'd0,  4'd0,  4'd0};

        clear_inputs();
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_g", 32'(bus.res_g), 32'd0);
        chk("rst_id", 32'(bus.res_id), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // (12,8) on requester 0: result 6 edges after accept.
        bus.res_ready = 1'b1;
        drive(1'b0, 4'd12, 4'd8);
        #1;
        chk("lat_rdy0", 32'(bus.req0_ready), 32'd1);
        chk("lat_rdy1", 32'(bus.req1_ready), 32'd0);
        tick();
        clear_inputs();
        chk("lat_busy", 32'(bus.busy), 32'd1);
        k = 0;
        while (!bus.res_valid && k < 20) begin
            tick();
            k++;
        end
        chk("lat_edges", 32'(k), 32'd6);
        chk("lat_g", 32'(bus.res_g), 32'd4);
        chk("lat_id", 32'(bus.res_id), 32'd0);
        tick();
        chk("lat_idle", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            base = nres;
            send(vt[i].id, vt[i].x, vt[i].y);
            wait_res(base + 1, 100);
            chk("vec_g", 32'(last_g), 32'(vt[i].g));
            chk("vec_id", 32'(last_id), 32'(vt[i].id));
        end

        // Both requesters valid from reset: 0 first, then 1, then 0.
        rst_n = 1'b0;
        sbq.delete();
        drive(1'b0, 4'd9, 4'd6);
        drive(1'b1, 4'd10, 4'd15);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rr_first0", 32'(bus.req0_ready), 32'd1);
        chk("rr_first1", 32'(bus.req1_ready), 32'd0);
        base = nres;
        wait_res(base + 2, 200);
        chk("rr_g2", 32'(last_g), 32'd5);
        chk("rr_id2", 32'(last_id), 32'd1);
        chk("rr_next0", 32'(bus.req0_ready), 32'd1);
        chk("rr_next1", 32'(bus.req1_ready), 32'd0);
        clear_inputs();

        // Zero operands finish on the edge after accept.
        drive(1'b1, 4'd0, 4'd7);
        #1;
        chk("z_rdy1", 32'(bus.req1_ready), 32'd1);
        tick();
        clear_inputs();
        chk("z_valid", 32'(bus.res_valid), 32'd1);
        chk("z_g7", 32'(bus.res_g), 32'd7);
        chk("z_id", 32'(bus.res_id), 32'd1);
        tick();
        drive(1'b1, 4'd0, 4'd0);
        #1;
        tick();
        clear_inputs();
        chk("z_valid0", 32'(bus.res_valid), 32'd1);
        chk("z_g0", 32'(bus.res_g), 32'd0);
        tick();

        // Consumer stalls: result holds, no new grants.
        bus.res_ready = 1'b0;
        send(1'b0, 4'd5, 4'd5);
        tick();
        chk("st_valid", 32'(bus.res_valid), 32'd1);
        drive(1'b0, 4'd3, 4'd6);
        drive(1'b1, 4'd9, 4'd3);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("st_hold_v", 32'(bus.res_valid), 32'd1);
            chk("st_hold_g", 32'(bus.res_g), 32'd5);
            chk("st_rdy0", 32'(bus.req0_ready), 32'd0);
            chk("st_rdy1", 32'(bus.req1_ready), 32'd0);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        clear_inputs();
        chk("st_idle", 32'(bus.busy), 32'd0);
        chk("st_done", 32'(bus.res_valid), 32'd0);
        chk("st_last_g", 32'(last_g), 32'd5);

        // Reset mid-RUN discards the transaction and re-arms priority.
        send(1'b1, 4'd15, 4'd10);
        tick();
        chk("rs_busy_run", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_busy", 32'(bus.busy), 32'd0);
        chk("rs_valid", 32'(bus.res_valid), 32'd0);
        chk("rs_g", 32'(bus.res_g), 32'd0);
        sbq.delete();
        base = nres;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rs_no_res", 32'(nres), 32'(base));
        drive(1'b0, 4'd15, 4'd10);
        drive(1'b1, 4'd3, 4'd9);
        #1;
        chk("rs_rdy0", 32'(bus.req0_ready), 32'd1);
        chk("rs_rdy1", 32'(bus.req1_ready), 32'd0);
        tick();
        clear_inputs();
        wait_res(base + 1, 100);
        chk("rs_g5", 32'(last_g), 32'd5);
        chk("rs_id0", 32'(last_id), 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits.
REQ-002 Port clk, input, 1: sole clock, rising-edge active.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port req0_valid, input, 1: requester 0 presents an operand pair.
REQ-005 Port req0_x / req0_y, input, WIDTH each: requester 0 operands.
REQ-006 Port req0_ready, output, 1: requester 0 pair accepted on the current edge when valid is also high.
REQ-007 Ports req1_valid, req1_x, req1_y, req1_ready: identical to REQ-004..006, for requester 1.
REQ-008 Port res_valid, output, 1: result available.
REQ-009 Port res_ready, input, 1: consumer takes the result.
REQ-010 Port res_g, output, WIDTH: GCD result.
REQ-011 Port res_id, output, 1: index of the requester that owns res_g.
REQ-012 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 The block SHALL share one iterative binary-GCD engine between two requesters through an FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, reqN_ready SHALL be high only for the granted requester, and only while that requester's valid is high; in every other state, both ready outputs SHALL be low.
REQ-015 Arbitration SHALL be round-robin: with both requesters valid, the grant goes to the requester not served last; with one valid, that requester wins; after reset, requester 0 wins first.
REQ-016 On acceptance, the block SHALL latch the operands into working registers a and b, clear a shift count, latch res_id, and update the last-served pointer.
REQ-017 If either accepted operand is 0, the block SHALL go directly to DONE with res_g = x OR y, so that gcd(0,0) = 0.
REQ-018 Otherwise the block SHALL enter RUN, where each edge performs exactly one step:
  - if a == b: load res_g = a shifted left by count, then go to DONE;
  - if both a and b are even: halve both and increment count;
  - if only a is even: halve a;
  - if only b is even: halve b;
  - if both are odd: subtract the smaller from the larger (a = a-b when a >= b, else b = b-a).
REQ-019 count width SHALL be clog2(WIDTH)+1; all arithmetic is unsigned, and no step may overflow WIDTH.
REQ-020 In DONE, res_valid SHALL be high and res_g/res_id SHALL hold stable until res_valid and res_ready are both high; that edge returns the FSM to IDLE.
REQ-021 Back-to-back transactions SHALL incur at least one IDLE cycle between DONE and the next acceptance.
REQ-022 Request inputs changing while the FSM is in RUN or DONE SHALL have no effect on the transaction in progress.

Reset
REQ-023 Assertion of rst_n low SHALL, asynchronously and at any point (including mid-RUN or in DONE):
  - force the FSM to IDLE;
  - set res_valid = 0, res_g = 0, res_id = 0 and busy = 0;
  - set the round-robin pointer so that requester 0 wins next;
  - clear a, b and count.
REQ-024 An in-flight transaction interrupted by reset SHALL be discarded, with no result produced.

Structure
REQ-025 Package gcd_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-026 The single-step datapath SHALL be the combinational sub-module gcd_step, taking a, b and count and producing next a, next b, next count and an equal flag; gcd_arbiter owns all registers and the arbitration logic.

Verification
REQ-027 req0 = (12,8) alone, res_ready high -> accepted; res_valid rises 6 edges after the accept edge; res_g = 4, res_id = 0.
REQ-028 req0 = (9,6) and req1 = (10,15) both held valid from reset, res_ready high -> first result g = 3 with id 0, then g = 5 with id 1; the next simultaneous pair is granted to requester 0.
REQ-029 req1 = (0,7), then (0,0) -> g = 7, then g = 0; each result is valid on the edge after acceptance.
REQ-030 req0 = (5,5), res_ready held low for 4 cycles -> res_valid stays high with g = 5 stable; req ready outputs stay low until the handshake completes, after which the FSM returns to IDLE.
REQ-031 rst_n pulsed low during RUN of (15,10) -> busy and res_valid drop immediately and no result appears; a fresh (15,10) request after reset returns g = 5 with id 0.
